multi_ctrl: RTL and testbench
=============================

MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset (0 = reset asserted immediately, independent of clk).
REQ-003 SHALL have ports: opcode  in  6  instruction bits [31:26] from the instruction register; funct is not used here.
REQ-004 SHALL have ports: mem_ready  in  1  memory handshake, 1 = current read or write completes this cycle.
REQ-005 SHALL have ports: ALUOP  out  3  ALU class to the ALU control decoder: R_TYPE=000, BEQ=001, ORI=010, LW=011, SW=100, JAL=101, JMP=110; 111 is never driven.
REQ-006 SHALL have ports: pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg, alu_src_a  out  1 each  datapath enables and selects.
REQ-007 SHALL have ports: alu_src_b, pc_src, reg_dst  out  2 each  mux selects; reg_dst: 00=rt, 01=rd, 10=$31.
REQ-008 SHALL have ports: state  out  4  current state code (debug); instr_done  out  1  one-cycle pulse at instruction retirement; illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-009 SHALL implement a Moore FSM; all outputs depend only on state, except pc_write_cond and the handshake stall, which may use mem_ready.
REQ-010 SHALL use these state codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, EXEC_ORI=9, ORI_WB=10, JUMP=11, JAL=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-011 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUOP=011 (add), pc_src=00; ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1, which also moves the FSM to DECODE; otherwise it stays in FETCH.
REQ-012 DECODE SHALL drive alu_src_a=0, alu_src_b=11, ALUOP=011 (branch target precompute), then branch on opcode: 000000 goes to EXEC_R; 100011 and 101011 go to MEM_ADDR; 000100 goes to BRANCH; 001101 goes to EXEC_ORI; 000010 goes to JUMP; 000011 goes to JAL; any other opcode goes to FETCH with illegal=1 for that cycle.
REQ-013 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, ALUOP=011 for lw or 100 for sw, then go to MEM_RD for lw or MEM_WR for sw.
REQ-014 MEM_RD SHALL drive mem_read=1, i_or_d=1, hold until mem_ready=1, then go to MEM_WB.
REQ-015 MEM_WR SHALL drive mem_write=1, i_or_d=1, hold until mem_ready=1, then go to FETCH with instr_done=1.
REQ-016 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=00, then go to FETCH with instr_done=1.
REQ-017 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, ALUOP=000; R_WB SHALL drive reg_write=1, reg_dst=01, mem_to_reg=0, then go to FETCH with instr_done=1.
REQ-018 EXEC_ORI SHALL drive alu_src_a=1, alu_src_b=10, ALUOP=010; ORI_WB SHALL drive reg_write=1, reg_dst=00, then go to FETCH with instr_done=1.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, ALUOP=001, pc_src=01, pc_write_cond=1, then go to FETCH with instr_done=1.
REQ-020 JUMP SHALL drive pc_src=10, pc_write=1, ALUOP=110; JAL SHALL drive pc_src=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=0, ALUOP=101; both SHALL then go to FETCH with instr_done=1.
REQ-021 Any output not listed for a state SHALL be 0.
REQ-022 mem_read and mem_write SHALL never both be 1, and reg_write SHALL never be 1 in FETCH or DECODE.
REQ-023 Latency in cycles with mem_ready held at 1: R, ori and lw take 4 and 5 respectively (R=4, ori=4, lw=5), sw=4, beq=3, j=3, jal=3; each cycle mem_ready is low in a memory state adds exactly 1.
REQ-024 opcode SHALL be sampled only in DECODE.

Reset
REQ-025 While rst=0, state SHALL be FETCH and every output SHALL be 0 except the FETCH combinational defaults with pc_write=0 and ir_write=0 forced; assertion mid-instruction SHALL abort it with no reg_write or mem_write pulse after the assert edge.
REQ-026 On the first rising clk after rst returns to 1, the FSM SHALL evaluate FETCH normally.

Verification
REQ-027 Release reset, apply opcode=000000 with mem_ready=1 -> states 0,1,6,7,0 in order; reg_dst=01 and reg_write=1 in state 7; instr_done pulses once.
REQ-028 Apply lw (100011) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles in total, mem_read=1 and i_or_d=1 throughout the stall, reg_write=1 only in MEM_WB.
REQ-029 Apply sw (101011) -> ALUOP=100 in MEM_ADDR, mem_write=1 only in MEM_WR, reg_write never asserted.
REQ-030 Apply opcode=111111 -> illegal=1 for exactly one cycle in DECODE, next state 0, no write enables asserted.
REQ-031 Apply jal (000011) -> reg_dst=10, reg_write=1 and pc_write=1 in one cycle, 3 cycles in total.
REQ-032 Assert rst=0 asynchronously mid-MEM_WR -> mem_write falls before the next clk edge, state=0.

Source files
------------

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-style main control unit.
// A Moore FSM sequences each instruction through fetch, decode and
// class-specific execute/memory/write-back states. It drives the datapath
// enables, the mux selects and the ALU class code. The current state code is
// exported on `state` for debug and checker binding.
//
// Memory handshake: in a memory state (FETCH, MEM_RD, MEM_WR) the access is
// outstanding until mem_ready=1. The cycle with mem_ready=1 is the completion
// cycle: any side effect tied to the access (ir_write/pc_write in FETCH,
// instr_done in MEM_WR) is asserted only in that cycle, and the FSM advances
// on the following clock edge. While mem_ready=0 the FSM holds its state and
// keeps the access strobes steady.
module multi_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] ALUOP,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_ORI = 4'd9,
    S_ORI_WB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_BEQ   = 3'b001;
  localparam logic [2:0] ALU_ORI   = 3'b010;
  localparam logic [2:0] ALU_LW    = 3'b011;
  localparam logic [2:0] ALU_SW    = 3'b100;
  localparam logic [2:0] ALU_JAL   = 3'b101;
  localparam logic [2:0] ALU_JMP   = 3'b110;

  state_t state_q, state_d;
  // Remembers lw vs sw from DECODE so MEM_ADDR never looks at opcode again.
  logic   is_sw_q, is_sw_d;

  // State register with asynchronous active-low reset into FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  // Next-state and Moore output decode; every output defaults to 0.
  always_comb begin
    state_d       = state_q;
    is_sw_d       = is_sw_q;
    ALUOP         = ALU_RTYPE;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    reg_dst       = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ALUOP     = ALU_LW;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ALUOP     = ALU_LW;
        case (opcode)
          OP_RTYPE: state_d = S_EXEC_R;
          OP_LW, OP_SW: begin
            state_d = S_MEM_ADDR;
            is_sw_d = (opcode == OP_SW);
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ORI:  state_d = S_EXEC_ORI;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUOP     = is_sw_q ? ALU_SW : ALU_LW;
        state_d   = is_sw_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ALUOP     = ALU_RTYPE;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ALUOP         = ALU_BEQ;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXEC_ORI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUOP     = ALU_ORI;
        state_d   = S_ORI_WB;
      end
      S_ORI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        ALUOP      = ALU_JMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        ALUOP      = ALU_JAL;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset holds FETCH but must not let a fetch complete.
    if (!rst) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_ctrl.sv
// Self-checking bench for multi_ctrl: directed scenarios plus a randomized
// instruction stream, checked cycle by cycle against a path/table model.
module tb_multi_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic [2:0] ALUOP;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src, reg_dst;
  logic [3:0] state;
  logic       instr_done, illegal;

  always #5 clk = ~clk;

  multi_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOP(ALUOP), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .reg_dst(reg_dst), .state(state), .instr_done(instr_done),
    .illegal(illegal)
  );

  int errors = 0;
  int checks = 0;

  // Expected per-cycle state path and mem_ready to drive for it.
  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  function automatic logic [17:0] act_ctrl();
    return {ALUOP, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
            i_or_d, reg_write, mem_to_reg, alu_src_a, alu_src_b, pc_src, reg_dst};
  endfunction

  // Control word each state must present, written from the state table.
  function automatic logic [17:0] exp_ctrl(int st, bit rdy, bit sw, bit in_rst);
    logic [2:0] alu = 3'b000;
    logic pw = 0, pwc = 0, irw = 0, mr = 0, mw = 0, iod = 0, rw = 0, m2r = 0, asa = 0;
    logic [1:0] asb = 2'b00, psrc = 2'b00, rdst = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; alu = 3'b011; if (rdy && !in_rst) begin irw = 1; pw = 1; end end
      1:  begin asb = 2'b11; alu = 3'b011; end
      2:  begin asa = 1; asb = 2'b10; alu = sw ? 3'b100 : 3'b011; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; alu = 3'b000; end
      7:  begin rw = 1; rdst = 2'b01; end
      8:  begin asa = 1; alu = 3'b001; psrc = 2'b01; pwc = 1; end
      9:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      10: begin rw = 1; end
      11: begin psrc = 2'b10; pw = 1; alu = 3'b110; end
      12: begin psrc = 2'b10; pw = 1; rw = 1; rdst = 2'b10; alu = 3'b101; end
      default: ;
    endcase
    return {alu, pw, pwc, irw, mr, mw, iod, rw, m2r, asa, asb, psrc, rdst};
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 ||
           op == 6'h0d || op == 6'h02 || op == 6'h03;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_st(input logic [3:0] st, input logic rdy);
    exp_q.push_back(st);
    rdy_q.push_back(rdy);
  endtask

  task automatic push_mem(input logic [3:0] st, input int stalls);
    for (int k = 0; k < stalls; k++) push_st(st, 1'b0);
    push_st(st, 1'b1);
  endtask

  // Runs one instruction from FETCH; caller is just after a rising edge.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input int fs, input int ms);
    bit sw, ill;
    int n;
    exp_q.delete();
    rdy_q.delete();
    sw  = (op == 6'h2b);
    ill = !is_legal(op);
    push_mem(4'd0, fs);
    push_st(4'd1, 1'($urandom_range(0, 1)));
    case (op)
      6'h00: begin push_st(4'd6, 1'($urandom_range(0, 1))); push_st(4'd7, 1'($urandom_range(0, 1))); end
      6'h23: begin push_st(4'd2, 1'($urandom_range(0, 1))); push_mem(4'd3, ms); push_st(4'd4, 1'($urandom_range(0, 1))); end
      6'h2b: begin push_st(4'd2, 1'($urandom_range(0, 1))); push_mem(4'd5, ms); end
      6'h04: push_st(4'd8, 1'($urandom_range(0, 1)));
      6'h0d: begin push_st(4'd9, 1'($urandom_range(0, 1))); push_st(4'd10, 1'($urandom_range(0, 1))); end
      6'h02: push_st(4'd11, 1'($urandom_range(0, 1)));
      6'h03: push_st(4'd12, 1'($urandom_range(0, 1)));
      default: ;
    endcase
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      logic [3:0] st;
      logic rdy;
      logic [17:0] ec;
      logic ed, ei;
      st = exp_q.pop_front();
      rdy = rdy_q.pop_front();
      opcode = (st == 4'd1) ? op : 6'($urandom);
      mem_ready = rdy;
      ec = exp_ctrl(int'(st), rdy, sw, 1'b0);
      ed = (i == n - 1) && !ill;
      ei = (i == n - 1) && ill;
      @(negedge clk);
      checks++;
      if (state !== st) begin
        errors++;
        $display("FAIL %s state cyc=%0d: got %0d expected %0d", name, i, state, st);
      end
      checks++;
      if (act_ctrl() !== ec) begin
        errors++;
        $display("FAIL %s ctrl cyc=%0d st=%0d: got %h expected %h", name, i, st, act_ctrl(), ec);
      end
      checks++;
      if (instr_done !== ed || illegal !== ei) begin
        errors++;
        $display("FAIL %s done/illegal cyc=%0d: got %b%b expected %b%b", name, i, instr_done, illegal, ed, ei);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL %s return_to_fetch: got %0d expected 0", name, state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'(i == 0);
      opcode = 6'($urandom);
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || act_ctrl() !== exp_ctrl(0, mem_ready, 1'b0, 1'b1) ||
          instr_done !== 1'b0 || illegal !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs rdy=%b: got st=%0d ctrl=%h d=%b i=%b expected st=0 ctrl=%h d=0 i=0",
                 mem_ready, state, act_ctrl(), instr_done, illegal, exp_ctrl(0, mem_ready, 1'b0, 1'b1));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_r_type();  run_instr("r_type", 6'h00, 0, 0); endtask
  task automatic test_lw_stall(); run_instr("lw_stall", 6'h23, 0, 2); endtask
  task automatic test_sw();      run_instr("sw", 6'h2b, 1, 1); endtask
  task automatic test_illegal(); run_instr("illegal", 6'h3f, 0, 0); endtask
  task automatic test_jal();     run_instr("jal", 6'h03, 0, 0); endtask

  task automatic test_back_to_back();
    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h0d, 6'h02, 6'h03};
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_async_reset();
    // Walk sw into MEM_WR and stall there.
    logic [3:0] pre [3] = '{4'd0, 4'd1, 4'd2};
    for (int i = 0; i < 3; i++) begin
      opcode = (pre[i] == 4'd1) ? 6'h2b : 6'h00;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got st=%0d mw=%b expected st=5 mw=1", state, mem_write);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: got st=%0d mw=%b rw=%b expected st=0 mw=0 rw=0", state, mem_write, reg_write);
    end
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
        errors++;
        $display("FAIL async_hold: got st=%0d mw=%b rw=%b irw=%b pw=%b expected 0 0 0 0 0",
                 state, mem_write, reg_write, ir_write, pc_write);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_instr("after_reset", 6'h00, 0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_r_type();
    test_lw_stall();
    test_sw();
    test_illegal();
    test_jal();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
